// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the word-packing UART transmitter.
// State encoding, parity modes and the ASCII hex lookup.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      if (nib < 4'd10)
         return 8'h30 + {4'h0, nib};
      else
         return 8'h37 + {4'h0, nib};
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO, registered read, power-of-two depth.
// A push while full and a pop while empty are both ignored.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int ASIZE = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [ASIZE:0]   level
);

   localparam int DEPTH = 1 << ASIZE;
   localparam logic [ASIZE:0] FULL_LVL = {1'b1, {ASIZE{1'b0}}};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [ASIZE-1:0] wptr;
   logic [ASIZE-1:0] rptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
         rdata <= '0;
      end else begin
         if (do_push)
            wptr <= wptr + 1'b1;
         if (do_pop) begin
            rptr  <= rptr + 1'b1;
            rdata <= mem[rptr];
         end
         unique case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_packer.sv
// Buffers multi-byte words and serialises them as UART frames.
// Define UART_TX_PACKER_HEX_EN to send each word as ASCII hex plus LF.
module uart_tx_packer
   import uart_tx_pkg::*;
#(
   parameter int UART_CLK_DIV = 434,
   parameter int FIFO_ASIZE   = 10,
   parameter int BYTE_WIDTH   = 1,
   parameter int BIG_ENDIAN   = 0,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wreq,
   output logic                    wgnt,
   input  logic [8*BYTE_WIDTH-1:0] wdata,
   output logic [FIFO_ASIZE:0]     fifo_level,
   output logic                    busy,
   output logic                    o_uart_tx
);

   localparam int WW = 8 * BYTE_WIDTH;
`ifdef UART_TX_PACKER_HEX_EN
   localparam int NCHAR = 2 * BYTE_WIDTH + 1;
`else
   localparam int NCHAR = BYTE_WIDTH;
`endif
   localparam logic [4:0] LAST_CHAR = 5'(NCHAR - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
   localparam int TW = $clog2(2 * UART_CLK_DIV);
   localparam logic [TW-1:0] T_LAST = TW'(2 * UART_CLK_DIV - 1);

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [2:0]      bit_q, bit_d;
   logic [4:0]      chr_q, chr_d;
   logic [WW-1:0]   word_q, word_d;
   logic            tx_q, tx_d;
   logic            pop;
   logic            full;
   logic            empty;
   logic [WW-1:0]   rdata;
   logic            tick;
   logic [7:0]      cur_char;
   logic            par_bit;

   uart_tx_fifo #(
      .WIDTH (WW),
      .ASIZE (FIFO_ASIZE)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wreq),
      .wdata (wdata),
      .pop   (pop),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

   assign wgnt      = !full;
   assign busy      = !empty || (state_q != S_IDLE);
   assign o_uart_tx = tx_q;
   assign tick      = (timer_q == T_LAST);

`ifdef UART_TX_PACKER_HEX_EN
   logic [3:0] nib;

   // Character 0 is the top nibble; the last character is the line feed.
   always_comb begin
      nib = '0;
      for (int i = 0; i < 2 * BYTE_WIDTH; i++)
         if (chr_q == 5'(2 * BYTE_WIDTH - 1 - i))
            nib = word_q[4*i +: 4];
      cur_char = (chr_q == LAST_CHAR) ? 8'h0A : hex_ascii(nib);
   end
`else
   always_comb begin
      cur_char = '0;
      for (int i = 0; i < BYTE_WIDTH; i++)
         if (chr_q == 5'((BIG_ENDIAN != 0) ? BYTE_WIDTH - 1 - i : i))
            cur_char = word_q[8*i +: 8];
   end
`endif

   assign par_bit = (PARITY == PAR_ODD) ? ~^cur_char : ^cur_char;

   always_comb begin
      state_d = state_q;
      timer_d = tick ? '0 : timer_q + 1'b1;
      bit_d   = bit_q;
      chr_d   = chr_q;
      word_d  = word_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            word_d  = rdata;
            chr_d   = '0;
            bit_d   = '0;
            timer_d = '0;
            state_d = S_START;
         end
         S_START: begin
            if (tick) begin
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tick) begin
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               bit_d   = '0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (bit_q != LAST_STOP) begin
                  bit_d = bit_q + 1'b1;
               end else if (chr_q != LAST_CHAR) begin
                  chr_d   = chr_q + 1'b1;
                  state_d = S_START;
               end else if (!empty) begin
                  pop     = 1'b1;
                  state_d = S_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The line is registered from the next state so it changes with it.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = cur_char[bit_d];
         S_PARITY: tx_d = par_bit;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         bit_q   <= '0;
         chr_q   <= '0;
         word_q  <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         chr_q   <= chr_d;
         word_q  <= word_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_packer.sv
// Directed bench: several uart_tx_packer configurations decoded
// by a bit-sampling receiver and compared against hand values.
module tb_uart_tx_packer;

   logic        clk;
   logic        rst_n;
   logic        wreq [6];
   logic        wgnt [6];
   logic        busy [6];
   logic        tx   [6];
   logic [2:0]  lv   [6];
   logic [31:0] wd   [6];

   int checks;
   int fails;
   int cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_packer #(.UART_CLK_DIV(4), .FIFO_ASIZE(2), .BYTE_WIDTH(1))
   u0 (.clk(clk), .rst_n(rst_n), .wreq(wreq[0]), .wgnt(wgnt[0]),
       .wdata(wd[0][7:0]), .fifo_level(lv[0]), .busy(busy[0]),
       .o_uart_tx(tx[0]));

   uart_tx_packer #(.UART_CLK_DIV(2), .FIFO_ASIZE(2), .BYTE_WIDTH(4),
                    .BIG_ENDIAN(0))
   u1 (.clk(clk), .rst_n(rst_n), .wreq(wreq[1]), .wgnt(wgnt[1]),
       .wdata(wd[1]), .fifo_level(lv[1]), .busy(busy[1]),
       .o_uart_tx(tx[1]));

   uart_tx_packer #(.UART_CLK_DIV(2), .FIFO_ASIZE(2), .BYTE_WIDTH(4),
                    .BIG_ENDIAN(1))
   u2 (.clk(clk), .rst_n(rst_n), .wreq(wreq[2]), .wgnt(wgnt[2]),
       .wdata(wd[2]), .fifo_level(lv[2]), .busy(busy[2]),
       .o_uart_tx(tx[2]));

   uart_tx_packer #(.UART_CLK_DIV(2), .FIFO_ASIZE(2), .BYTE_WIDTH(1),
                    .PARITY(1), .STOP_BITS(2))
   u3 (.clk(clk), .rst_n(rst_n), .wreq(wreq[3]), .wgnt(wgnt[3]),
       .wdata(wd[3][7:0]), .fifo_level(lv[3]), .busy(busy[3]),
       .o_uart_tx(tx[3]));

   uart_tx_packer #(.UART_CLK_DIV(2), .FIFO_ASIZE(2), .BYTE_WIDTH(1),
                    .PARITY(2), .STOP_BITS(2))
   u4 (.clk(clk), .rst_n(rst_n), .wreq(wreq[4]), .wgnt(wgnt[4]),
       .wdata(wd[4][7:0]), .fifo_level(lv[4]), .busy(busy[4]),
       .o_uart_tx(tx[4]));

   uart_tx_packer #(.UART_CLK_DIV(2), .FIFO_ASIZE(2), .BYTE_WIDTH(2))
   u5 (.clk(clk), .rst_n(rst_n), .wreq(wreq[5]), .wgnt(wgnt[5]),
       .wdata(wd[5][15:0]), .fifo_level(lv[5]), .busy(busy[5]),
       .o_uart_tx(tx[5]));

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic put(input int u, input logic [31:0] d);
      @(negedge clk);
      chk($sformatf("put_gnt%0d", u), 32'(wgnt[u]), 1);
      wreq[u] = 1'b1;
      wd[u]   = d;
      @(posedge clk);
      #1 wreq[u] = 1'b0;
   endtask

   // Waits for a start bit, then samples mid-bit; ok drops on a bad
   // start or stop bit or when no frame appears in time.
   task automatic rx(input int u, input int p, input int np,
                     input int ns, output logic [7:0] d,
                     output logic pb, output logic ok, output int ts);
      int n;
      ok = 1'b1;
      d  = '0;
      pb = 1'b0;
      ts = 0;
      n  = 0;
      @(negedge clk);
      while (tx[u] && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (tx[u]) begin
         ok = 1'b0;
         return;
      end
      ts = cyc;
      repeat (p / 2) @(negedge clk);
      if (tx[u]) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (p) @(negedge clk);
         d[i] = tx[u];
      end
      if (np != 0) begin
         repeat (p) @(negedge clk);
         pb = tx[u];
      end
      for (int i = 0; i < ns; i++) begin
         repeat (p) @(negedge clk);
         if (!tx[u]) ok = 1'b0;
      end
   endtask

   task automatic wait_idle(input int u, output int c);
      int n;
      n = 0;
      while (busy[u] && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("idle%0d", u), 32'(busy[u]), 0);
      c = cyc;
   endtask

   task automatic word_test(input int u, input logic [31:0] w,
                            input logic [31:0] exp);
      logic [7:0] d;
      logic       pb;
      logic       ok;
      int         ts;
      int         prev;
      prev = 0;
      put(u, w);
      for (int k = 0; k < 4; k++) begin
         rx(u, 4, 0, 1, d, pb, ok, ts);
         chk($sformatf("w%0d_b%0d", u, k), 32'(d), 32'(exp[8*k +: 8]));
         chk($sformatf("w%0d_ok%0d", u, k), 32'(ok), 1);
         if (k > 0)
            chk($sformatf("w%0d_gap%0d", u, k), 32'(ts - prev), 40);
         prev = ts;
      end
   endtask

   task automatic par_test(input int u, input logic [7:0] w,
                           input logic exp_pb);
      logic [7:0] d;
      logic       pb;
      logic       ok;
      int         ts;
      int         c;
      put(u, 32'(w));
      rx(u, 4, 1, 2, d, pb, ok, ts);
      chk($sformatf("par%0d_d", u), 32'(d), 32'(w));
      chk($sformatf("par%0d_pb", u), 32'(pb), 32'(exp_pb));
      chk($sformatf("par%0d_ok", u), 32'(ok), 1);
      wait_idle(u, c);
      chk($sformatf("par%0d_len", u), 32'(c - ts), 48);
   endtask

   logic [7:0] rxd  [5];
   logic       rxok [5];

   initial begin
      #1000000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [7:0] d;
      logic       pb;
      logic       ok;
      int         ts;
      int         t0;
      int         c;
      int         n;
      int         acc;
      checks = 0;
      fails  = 0;
      rst_n  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         wreq[i] = 1'b0;
         wd[i]   = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx[0]), 1);
      chk("rst_gnt", 32'(wgnt[0]), 1);
      chk("rst_lvl", 32'(lv[0]), 0);
      chk("rst_busy", 32'(busy[0]), 0);
      rst_n = 1'b1;

`ifdef UART_TX_PACKER_HEX_EN
      put(5, 32'h0000A50F);
      for (int k = 0; k < 5; k++) begin
         rx(5, 4, 0, 1, d, pb, ok, ts);
         chk($sformatf("hex_ok%0d", k), 32'(ok), 1);
         case (k)
            0: chk("hex0", 32'(d), 32'h41);
            1: chk("hex1", 32'(d), 32'h35);
            2: chk("hex2", 32'(d), 32'h30);
            3: chk("hex3", 32'(d), 32'h46);
            default: chk("hex_lf", 32'(d), 32'h0A);
         endcase
      end
      wait_idle(5, c);
`else
      // Single byte: latency, bit values, frame length.
      @(negedge clk);
      wreq[0] = 1'b1;
      wd[0]   = 32'h55;
      @(posedge clk);
      #1 wreq[0] = 1'b0;
      @(negedge clk);
      chk("t1_lvl", 32'(lv[0]), 1);
      chk("t1_busy", 32'(busy[0]), 1);
      chk("t1_tx_t1", 32'(tx[0]), 1);
      @(negedge clk);
      chk("t1_tx_t2", 32'(tx[0]), 1);
      @(negedge clk);
      chk("t1_tx_t3", 32'(tx[0]), 0);
      t0 = cyc;
      rx(0, 8, 0, 1, d, pb, ok, ts);
      chk("t1_data", 32'(d), 32'h55);
      chk("t1_ok", 32'(ok), 1);
      wait_idle(0, c);
      chk("t1_len", 32'(c - t0), 80);

      word_test(1, 32'h12345678, 32'h12345678);
      word_test(2, 32'h12345678, 32'h78563412);

      par_test(3, 8'h03, 1'b1);
      par_test(3, 8'h07, 1'b0);
      par_test(4, 8'h03, 1'b0);
      par_test(4, 8'h01, 1'b1);

      put(5, 32'h0000A50F);
      rx(5, 4, 0, 1, d, pb, ok, ts);
      chk("w5_b0", 32'(d), 32'h0F);
      rx(5, 4, 0, 1, d, pb, ok, ts);
      chk("w5_b1", 32'(d), 32'hA5);
      chk("w5_ok", 32'(ok), 1);

      // FIFO fill while a frame is already on the line.
      acc = 0;
      put(0, 32'hC3);
      fork
         begin
            logic [7:0] fd;
            logic       fpb;
            logic       fok;
            int         fts;
            for (int k = 0; k < 5; k++) begin
               rx(0, 8, 0, 1, fd, fpb, fok, fts);
               rxd[k]  = fd;
               rxok[k] = fok;
            end
         end
         begin
            repeat (5) @(negedge clk);
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               if (lv[0] == 3'd4)
                  chk("full_gnt", 32'(wgnt[0]), 0);
               wreq[0] = 1'b1;
               wd[0]   = 32'h20 + 32'(i);
               if (wgnt[0]) acc++;
            end
            @(negedge clk);
            wreq[0] = 1'b0;
            chk("full_lvl", 32'(lv[0]), 4);
         end
      join
      chk("acc_cnt", 32'(acc), 4);
      chk("fifo_w0", 32'(rxd[0]), 32'hC3);
      for (int k = 1; k < 5; k++) begin
         chk($sformatf("fifo_w%0d", k), 32'(rxd[k]), 32'h1F + 32'(k));
         chk($sformatf("fifo_ok%0d", k), 32'(rxok[k]), 1);
      end
      wait_idle(0, c);

      // Reset in the middle of the data bits of a zero byte.
      put(0, 32'h00);
      put(0, 32'hFF);
      n = 0;
      while (tx[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (36) @(negedge clk);
      chk("t5_pre", 32'(tx[0]), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_tx", 32'(tx[0]), 1);
      chk("t5_lvl", 32'(lv[0]), 0);
      chk("t5_busy", 32'(busy[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      put(0, 32'h3C);
      rx(0, 8, 0, 1, d, pb, ok, ts);
      chk("t5_data", 32'(d), 32'h3C);
      chk("t5_ok", 32'(ok), 1);
      wait_idle(0, c);
      n = 0;
      repeat (100) begin
         @(negedge clk);
         if (!tx[0]) n++;
      end
      chk("t5_quiet", 32'(n), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
